// File: rtl/antidroop_cal_ctrl_if.sv
// Signal bundle between the anti-droop calibration controller and its
// environment. The controller sits on the slave side; the environment
// (datapath glue or bench) drives from the master side.
// There is no valid/ready handshake: inputs are sampled every rising clk
// edge, and every output is stable between edges.
interface antidroop_cal_ctrl_if #(
  parameter int WIN_W = 12
);
  logic              enable;
  logic              trig;
  logic signed [6:0] target_weight;
  logic [WIN_W-1:0]  win_len;
  logic [7:0]        oflow_thresh;
  logic              oflowDetect;
  logic              clr_flags;
  logic signed [6:0] tapWeight;
  logic              accClr_en;
  logic              busy;
  logic              backoff;
  logic [7:0]        oflow_count;
  logic [1:0]        state_dbg;

  modport master (
    output enable, trig, target_weight, win_len, oflow_thresh, oflowDetect, clr_flags,
    input  tapWeight, accClr_en, busy, backoff, oflow_count, state_dbg
  );

  modport slave (
    input  enable, trig, target_weight, win_len, oflow_thresh, oflowDetect, clr_flags,
    output tapWeight, accClr_en, busy, backoff, oflow_count, state_dbg
  );
endinterface

// File: rtl/antidroop_cal_ctrl.sv
// Anti-droop IIR calibration controller. After each beam trigger it counts
// overflow cycles over a window. Once the window completes, the tap weight
// ramps toward the target while overflow stays within tolerance. It backs
// off toward zero, and then freezes, when the tolerance is exceeded.
module antidroop_cal_ctrl #(
  parameter int RAMP_STEP = 1,
  parameter int WIN_W     = 12
) (
  input logic                 clk,
  input logic                 rst,
  antidroop_cal_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    WINDOW    = 2'd2,
    EVAL      = 2'd3
  } state_t;

  localparam logic signed [7:0] STEP8 = 8'(RAMP_STEP);

  state_t            state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [7:0]        ocnt_q, ocnt_d;
  logic [7:0]        ocount_q, ocount_d;
  logic signed [6:0] tap_q, tap_d;
  logic              acc_q, acc_d;
  logic              backoff_q, backoff_d;
  logic              freeze_q, freeze_d;

  logic              trig_edge;
  logic [WIN_W-1:0]  win_load;
  logic signed [7:0] w8, t8, up8, dn8, toward_t8, toward_0_8;

  // Clamp an 8-bit intermediate weight into the 7-bit signed range.
  function automatic logic signed [6:0] sat7(input logic signed [7:0] v);
    if (v > 8'sd63)       sat7 = 7'sb0111111;
    else if (v < -8'sd64) sat7 = 7'sb1000000;
    else                  sat7 = v[6:0];
  endfunction

  assign trig_edge = s1_q & ~s2_q;
  assign win_load  = (bus.win_len == '0) ? '0 : bus.win_len - 1'b1;

  // One-step weight candidates: toward the target without overshoot, and toward zero.
  always_comb begin
    w8  = {tap_q[6], tap_q};
    t8  = {bus.target_weight[6], bus.target_weight};
    up8 = w8 + STEP8;
    dn8 = w8 - STEP8;
    toward_t8 = w8;
    if (w8 < t8)      toward_t8 = (up8 > t8) ? t8 : up8;
    else if (w8 > t8) toward_t8 = (dn8 < t8) ? t8 : dn8;
    toward_0_8 = '0;
    if (w8 > 8'sd0)      toward_0_8 = (dn8 < 8'sd0) ? 8'sd0 : dn8;
    else if (w8 < 8'sd0) toward_0_8 = (up8 > 8'sd0) ? 8'sd0 : up8;
  end

  // Next-state, counter and weight update logic for the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    s1_d      = bus.trig;
    s2_d      = s1_q;
    win_cnt_d = win_cnt_q;
    ocnt_d    = ocnt_q;
    ocount_d  = ocount_q;
    tap_d     = tap_q;
    acc_d     = (state_q == WAIT_TRIG);
    backoff_d = backoff_q;
    freeze_d  = freeze_q;

    // Clear first so that a simultaneous back-off below overrides it.
    if (bus.clr_flags) begin
      backoff_d = 1'b0;
      freeze_d  = 1'b0;
    end

    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_TRIG;
        WAIT_TRIG: begin
          if (trig_edge) begin
            state_d   = WINDOW;
            win_cnt_d = win_load;
            ocnt_d    = '0;
          end
        end
        WINDOW: begin
          if (bus.oflowDetect && (ocnt_q != 8'hFF)) ocnt_d = ocnt_q + 8'd1;
          if (win_cnt_q == '0) state_d = EVAL;
          else                 win_cnt_d = win_cnt_q - 1'b1;
        end
        EVAL: begin
          state_d  = WAIT_TRIG;
          ocount_d = ocnt_q;
          if (ocnt_q > bus.oflow_thresh) begin
            backoff_d = 1'b1;
            freeze_d  = 1'b1;
            tap_d     = sat7(toward_0_8);
          end else if (!freeze_q) begin
            tap_d = sat7(toward_t8);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      win_cnt_q <= '0;
      ocnt_q    <= '0;
      ocount_q  <= '0;
      tap_q     <= '0;
      acc_q     <= 1'b0;
      backoff_q <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      win_cnt_q <= win_cnt_d;
      ocnt_q    <= ocnt_d;
      ocount_q  <= ocount_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      backoff_q <= backoff_d;
      freeze_q  <= freeze_d;
    end
  end

  assign bus.tapWeight   = tap_q;
  assign bus.accClr_en   = acc_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.backoff     = backoff_q;
  assign bus.oflow_count = ocount_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_antidroop_cal_ctrl.sv
// Bench for antidroop_cal_ctrl. Two instances (ramp step 1 and 4) share one
// stimulus stream. A window-level reference model predicts weight, flags and
// overflow count from the trigger/overflow pattern the bench itself drives.
module tb_antidroop_cal_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  antidroop_cal_ctrl_if #(.WIN_W(12)) bus1 ();
  antidroop_cal_ctrl_if #(.WIN_W(12)) bus4 ();

  antidroop_cal_ctrl #(.RAMP_STEP(1), .WIN_W(12)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  antidroop_cal_ctrl #(.RAMP_STEP(4), .WIN_W(12)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus4.enable        = bus1.enable;
  assign bus4.trig          = bus1.trig;
  assign bus4.target_weight = bus1.target_weight;
  assign bus4.win_len       = bus1.win_len;
  assign bus4.oflow_thresh  = bus1.oflow_thresh;
  assign bus4.oflowDetect   = bus1.oflowDetect;
  assign bus4.clr_flags     = bus1.clr_flags;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  // reference model state
  int m_w1, m_w4, m_ocount, m_target, m_thresh;
  bit m_freeze, m_backoff;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int toward(input int w, input int d, input int s);
    int r;
    if (w < d)      r = (w + s > d) ? d : w + s;
    else if (w > d) r = (w - s < d) ? d : w - s;
    else            r = w;
    if (r > 63)  r = 63;
    if (r < -64) r = -64;
    return r;
  endfunction

  function automatic void model_reset();
    m_w1 = 0; m_w4 = 0; m_ocount = 0; m_freeze = 0; m_backoff = 0;
  endfunction

  function automatic void model_eval(input int n_of, input bit clr);
    int cnt;
    cnt = (n_of > 255) ? 255 : n_of;
    m_ocount = cnt;
    if (cnt > m_thresh) begin
      m_w1 = toward(m_w1, 0, 1);
      m_w4 = toward(m_w4, 0, 4);
      m_freeze = 1; m_backoff = 1;
    end else begin
      if (!m_freeze) begin
        m_w1 = toward(m_w1, m_target, 1);
        m_w4 = toward(m_w4, m_target, 4);
      end
      if (clr) begin m_freeze = 0; m_backoff = 0; end
    end
    exp_q.push_back(7'(m_w1));
  endfunction

  task automatic set_cfg(input int target, input int thresh);
    m_target = target; m_thresh = thresh;
    bus1.target_weight = 7'(target);
    bus1.oflow_thresh  = 8'(thresh);
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] e;
    chk({tag, "_tap1"}, int'($signed(bus1.tapWeight)), m_w1);
    chk({tag, "_tap4"}, int'($signed(bus4.tapWeight)), m_w4);
    chk({tag, "_ocount"}, int'(bus1.oflow_count), m_ocount);
    chk({tag, "_backoff1"}, int'(bus1.backoff), int'(m_backoff));
    chk({tag, "_backoff4"}, int'(bus4.backoff), int'(m_backoff));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_sb"}, int'($signed(bus1.tapWeight)), int'($signed(e)));
    end
  endtask

  // One full trigger -> window -> eval sequence. n_force < 0 gives random
  // overflow, otherwise the first n_force window cycles carry overflow.
  task automatic run_window(input int len_in, input int n_force, input bit retrig, input bit clr_eval);
    int L;
    int n_of;
    bit od;
    L = (len_in == 0) ? 1 : len_in;
    n_of = 0;
    repeat (2) @(negedge clk);
    chk("acc_wait_trig", int'(bus1.accClr_en), 1);
    bus1.win_len = 12'(len_in);
    bus1.trig = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      if (i == 0) bus1.trig = 1'b0;
      if (retrig && L >= 8 && i == 1) bus1.trig = 1'b1;
      if (retrig && L >= 8 && i == 3) bus1.trig = 1'b0;
      od = (n_force < 0) ? ($urandom_range(0, 2) == 0) : (i < n_force);
      bus1.oflowDetect = od;
      if (od) n_of++;
      @(posedge clk);
    end
    @(negedge clk);
    bus1.oflowDetect = 1'b0;
    bus1.clr_flags = clr_eval;
    chk("acc_eval", int'(bus1.accClr_en), 0);
    chk("busy_eval", int'(bus1.busy), 1);
    chk("tap_hold_in_window", int'($signed(bus1.tapWeight)), m_w1);
    @(posedge clk);
    @(negedge clk);
    bus1.clr_flags = 1'b0;
    model_eval(n_of, clr_eval);
    check_outputs("eval");
    chk("acc_after_eval", int'(bus1.accClr_en), 0);
    @(posedge clk);
    @(negedge clk);
    chk("acc_lag", int'(bus1.accClr_en), 1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus1.clr_flags = 1'b1;
    @(negedge clk);
    bus1.clr_flags = 1'b0;
    m_freeze = 0; m_backoff = 0;
    chk("backoff_clr", int'(bus1.backoff), 0);
  endtask

  // Start a window and leave it a few cycles in with trig low.
  task automatic start_partial_window(input int len_in);
    repeat (2) @(negedge clk);
    bus1.win_len = 12'(len_in);
    bus1.trig = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus1.trig = 1'b0;
      bus1.oflowDetect = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tap1"}, int'($signed(bus1.tapWeight)), 0);
    chk({tag, "_tap4"}, int'($signed(bus4.tapWeight)), 0);
    chk({tag, "_acc"}, int'(bus1.accClr_en), 0);
    chk({tag, "_busy"}, int'(bus1.busy), 0);
    chk({tag, "_backoff"}, int'(bus1.backoff), 0);
    chk({tag, "_ocount"}, int'(bus1.oflow_count), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ramp_exp[6];
    int guard;
    ramp_exp = '{1, 2, 3, 4, 5, 5};
    rst = 1'b1;
    bus1.enable = 1'b0; bus1.trig = 1'b0; bus1.oflowDetect = 1'b0; bus1.clr_flags = 1'b0;
    bus1.win_len = '0;
    set_cfg(0, 255);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bus1.busy), 0);
    bus1.enable = 1'b1;

    // ramp toward +5 with no overflow tolerance issue
    set_cfg(5, 255);
    for (int i = 0; i < 6; i++) begin
      run_window(100, 0, 0, 0);
      chk("ramp_tap1", int'($signed(bus1.tapWeight)), ramp_exp[i]);
    end

    // back-off, freeze, clear
    set_cfg(10, 255);
    guard = 0;
    while (m_w1 != 10 && guard < 20) begin run_window(5, 0, 0, 0); guard++; end
    set_cfg(20, 3);
    run_window(8, 4, 0, 0);
    chk("backoff_tap", int'($signed(bus1.tapWeight)), 9);
    chk("backoff_ocount", int'(bus1.oflow_count), 4);
    chk("backoff_flag", int'(bus1.backoff), 1);
    run_window(8, 0, 0, 0);
    chk("freeze_hold", int'($signed(bus1.tapWeight)), 9);
    pulse_clr();
    run_window(8, 0, 0, 0);
    chk("unfreeze_tap", int'($signed(bus1.tapWeight)), 10);

    // negative ramp and clamp at -64, then back-off from -2 with step 4
    set_cfg(-64, 255);
    for (int i = 0; i < 20; i++) run_window(3, 0, 0, 0);
    chk("neg_clamp_tap4", int'($signed(bus4.tapWeight)), -64);
    set_cfg(-2, 255);
    guard = 0;
    while (m_w4 != -2 && guard < 30) begin run_window(2, 0, 0, 0); guard++; end
    chk("reach_m2_tap4", int'($signed(bus4.tapWeight)), -2);
    set_cfg(-2, 0);
    run_window(3, 3, 0, 0);
    chk("backoff_m2_tap4", int'($signed(bus4.tapWeight)), 0);

    // window edges: zero length, saturation, retrigger, clear coinciding with back-off
    pulse_clr();
    set_cfg(7, 255);
    run_window(0, 1, 0, 0);
    chk("win0_ocount", int'(bus1.oflow_count), 1);
    run_window(4000, 4000, 0, 0);
    chk("sat_ocount", int'(bus1.oflow_count), 255);
    run_window(20, -1, 1, 0);
    run_window(20, -1, 1, 0);
    set_cfg(7, 0);
    run_window(4, 2, 0, 1);
    chk("clr_vs_set", int'(bus1.backoff), 1);

    // randomized windows
    for (int k = 0; k < 40; k++) begin
      set_cfg(int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 4) == 0) pulse_clr();
      run_window(int'($urandom_range(0, 12)), -1, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
    end

    // enable dropped mid-window
    start_partial_window(10);
    @(negedge clk);
    bus1.enable = 1'b0;
    bus1.oflowDetect = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(bus1.busy), 0);
    check_outputs("abort");
    bus1.enable = 1'b1;
    run_window(6, -1, 0, 0);

    // asynchronous reset mid-window
    start_partial_window(10);
    @(negedge clk);
    bus1.oflowDetect = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_cfg(3, 255);
    run_window(6, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/antidroop_cal_ctrl.md
ANTIDROOP_CAL_CTRL -- requirements
Module: antidroop_cal_ctrl

Interface
REQ-001 Parameter RAMP_STEP, default 1: tapWeight change per trigger pulse, in LSBs (1..63).
REQ-002 Parameter WIN_W, default 12: width of win_len.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  level; high = calibration sequencing active.
REQ-006 trig  in  1  beam trigger, asynchronous to clk, same signal fed to the IIR datapath.
REQ-007 target_weight  in  7  signed requested IIR tap weight.
REQ-008 win_len  in  WIN_W  unsigned overflow-observation window length in cycles.
REQ-009 oflow_thresh  in  8  unsigned overflow-cycle count tolerated per window.
REQ-010 oflowDetect  in  1  overflow flag from the IIR datapath.
REQ-011 clr_flags  in  1  single-cycle pulse; clears backoff and freeze.
REQ-012 tapWeight  out  7  signed weight driven to the IIR datapath, registered.
REQ-013 accClr_en  out  1  accumulator-clear enable to the datapath, registered.
REQ-014 busy  out  1  high when state is not IDLE.
REQ-015 backoff  out  1  sticky flag: a weight back-off has occurred.
REQ-016 oflow_count  out  8  overflow-cycle count of the last completed window.

Function
REQ-017 trig SHALL pass through a 2-flop synchroniser (s1, s2); trig_edge = s1 & ~s2.
REQ-018 The FSM SHALL have states IDLE, WAIT_TRIG, WINDOW and EVAL.
REQ-019 IDLE: enable=1 -> WAIT_TRIG next cycle; otherwise remain.
REQ-020 WAIT_TRIG: trig_edge=1 -> WINDOW; load the window counter with max(win_len,1)-1; zero the overflow counter.
REQ-021 WINDOW: each cycle, oflowDetect=1 SHALL increment the overflow counter, saturating at 255; counter=0 -> EVAL; otherwise decrement.
REQ-022 trig_edge during WINDOW or EVAL SHALL be ignored and SHALL NOT restart the window.
REQ-023 EVAL lasts exactly one cycle; oflow_count SHALL load the overflow counter; next state is WAIT_TRIG.
REQ-024 EVAL with count > oflow_thresh: backoff and freeze SHALL set; tapWeight SHALL move RAMP_STEP toward 0, clamped at 0.
REQ-025 EVAL with count <= oflow_thresh and freeze=0: tapWeight SHALL move RAMP_STEP toward target_weight without overshoot.
REQ-026 EVAL with count <= oflow_thresh and freeze=1: tapWeight SHALL hold.
REQ-027 Weight arithmetic SHALL be done at 8 bits and clamped to [-64, 63].
REQ-028 tapWeight SHALL change only in the cycle after EVAL and never mid-window.
REQ-029 accClr_en SHALL be 1 while in WAIT_TRIG and 0 in all other states, registered (one-cycle lag from state).
REQ-030 enable=0 in any state -> IDLE next cycle; tapWeight, oflow_count and flags hold; counters are abandoned.
REQ-031 clr_flags SHALL clear backoff and freeze; when it coincides with an EVAL back-off, set wins.
REQ-032 Latency: trig rising -> trig_edge after 2 clk edges -> WINDOW for max(win_len,1) cycles -> EVAL -> tapWeight update on the following edge.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, tapWeight=0, accClr_en=0, busy=0, backoff=0, freeze=0, oflow_count=0, and clear the synchroniser and counters.
REQ-034 rst deasserting mid-window SHALL restart from IDLE with no partial window evaluated.

Verification
REQ-035 Ramp: target=5, thresh=255, win_len=100, 6 trigs -> tapWeight 1,2,3,4,5,5; accClr_en=1 only in WAIT_TRIG.
REQ-036 Back-off: tapWeight=10, target=20, thresh=3, oflowDetect high 4 cycles in window -> oflow_count=4, tapWeight=9, backoff=1; the next clean window holds 9; clr_flags then the next clean window -> 10.
REQ-037 Negative/clamp: target=-64, RAMP_STEP=4, start 0 -> reaches -64 and holds; back-off from -2 with RAMP_STEP=4 -> 0.
REQ-038 Window edges: win_len=0 -> 1-cycle window; oflowDetect constant 1 with win_len=4000 -> oflow_count=255; retrigger during window ignored.
REQ-039 Abort: enable low mid-window -> IDLE next cycle, tapWeight unchanged; async rst mid-window -> all outputs at reset values before the next clk edge.
